// File: rtl/gcl_step_engine.sv
// Small-step evaluator for the guarded-command language with exceptions.
// One instruction per fetch/exec pair; handler stack, step budget, host var port.
module gcl_step_engine #(
    parameter int WIDTH  = 16,
    parameter int NVARS  = 8,
    parameter int PC_W   = 10,
    parameter int HDEPTH = 4,
    parameter int CNT_W  = 16,
    localparam int VAR_W = $clog2(NVARS),
    localparam int IW    = 4 + 2 * VAR_W + WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [2:0]       outcome,
    output logic [CNT_W-1:0] steps,
    output logic             fetch_req,
    output logic [PC_W-1:0]  fetch_addr,
    input  logic             fetch_ack,
    input  logic [IW-1:0]    fetch_data,
    input  logic             choice,
    input  logic             var_we,
    input  logic [VAR_W-1:0] var_addr,
    input  logic [WIDTH-1:0] var_wdata,
    output logic [WIDTH-1:0] var_rdata
);
    localparam int SP_W = $clog2(HDEPTH + 1);
    localparam int HI_W = (HDEPTH > 1) ? $clog2(HDEPTH) : 1;

    localparam logic [2:0] R_NORMAL = 3'd0;
    localparam logic [2:0] R_EXCEPT = 3'd1;
    localparam logic [2:0] R_WRONG  = 3'd2;
    localparam logic [2:0] R_BLOCK  = 3'd3;
    localparam logic [2:0] R_OVER   = 3'd4;
    localparam logic [2:0] R_UNDER  = 3'd5;
    localparam logic [2:0] R_TMO    = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;
    state_t state, state_nxt;

    logic [PC_W-1:0]  pc;
    logic [SP_W-1:0]  sp;
    logic [IW-1:0]    instr;
    logic [WIDTH-1:0] vars [NVARS];
    logic [PC_W-1:0]  hstk [HDEPTH];

    logic [3:0]       op;
    logic [VAR_W-1:0] ra, rb;
    logic [WIDTH-1:0] imm, va;
    logic [PC_W-1:0]  tgt, pc_nxt;
    logic [CNT_W-1:0] steps_nxt;
    logic [2:0]       res;
    logic             term, fin, push, pop, wr, go;

    assign op  = instr[3:0];
    assign ra  = instr[4 +: VAR_W];
    assign rb  = instr[4 + VAR_W +: VAR_W];
    assign imm = instr[IW-1 -: WIDTH];
    assign tgt = imm[PC_W-1:0];
    assign va  = vars[ra];
    assign go  = start && (state == S_IDLE || state == S_DONE);
    assign steps_nxt = steps + 1'b1;
    // the instruction's own outcome wins over running out of budget
    assign fin = term || (steps_nxt == '1);

    always_comb begin
        pc_nxt = pc + 1'b1;
        term   = 1'b0;
        res    = R_NORMAL;
        push   = 1'b0;
        pop    = 1'b0;
        wr     = 1'b0;
        case (op)
            4'd1: wr = 1'b1;
            4'd2: if (va == '0) begin term = 1'b1; res = R_WRONG; end
            4'd3: if (va == '0) begin term = 1'b1; res = R_BLOCK; end
            4'd4: if (choice) pc_nxt = tgt;
            4'd5: pc_nxt = tgt;
            4'd6: begin
                if (sp == SP_W'(HDEPTH)) begin term = 1'b1; res = R_OVER; end
                else push = 1'b1;
            end
            4'd7: begin
                if (sp == '0) begin term = 1'b1; res = R_UNDER; end
                else pop = 1'b1;
            end
            4'd8: begin
                if (sp == '0) begin
                    term = 1'b1;
                    res  = R_EXCEPT;
                end else begin
                    pop    = 1'b1;
                    pc_nxt = hstk[HI_W'(sp - 1'b1)];
                end
            end
            4'd9: term = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: if (fetch_ack) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = fin ? S_DONE : S_FETCH;
            S_DONE:  if (start) state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        busy      = (state == S_FETCH) || (state == S_EXEC);
        done      = (state == S_DONE);
        fetch_req = (state == S_FETCH);
    end

    assign fetch_addr = pc;
    assign var_rdata  = vars[var_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= '0;
            sp      <= '0;
            steps   <= '0;
            outcome <= R_NORMAL;
            instr   <= '0;
        end else if (go) begin
            pc      <= '0;
            sp      <= '0;
            steps   <= '0;
            outcome <= R_NORMAL;
        end else if (state == S_FETCH && fetch_ack) begin
            instr <= fetch_data;
        end else if (state == S_EXEC) begin
            steps <= steps_nxt;
            if (!term) pc <= pc_nxt;
            if (push) sp <= sp + 1'b1;
            if (pop)  sp <= sp - 1'b1;
            if (term)     outcome <= res;
            else if (fin) outcome <= R_TMO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HDEPTH; i++) hstk[i] <= '0;
        end else if (state == S_EXEC && push) begin
            hstk[HI_W'(sp)] <= tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NVARS; i++) vars[i] <= '0;
        end else if (state == S_EXEC && wr) begin
            vars[ra] <= vars[rb] + imm;
        end else if (var_we && !busy) begin
            vars[var_addr] <= var_wdata;
        end
    end
endmodule

// File: tb/tb_gcl_step_engine.sv
// Directed bench for gcl_step_engine: small programs from a fetch model,
// hand-computed outcomes, steps and variable values.
module tb_gcl_step_engine;
    localparam int WIDTH = 16, NVARS = 8, PC_W = 10, HDEPTH = 4, CNT_W = 4;
    localparam int VAR_W = 3;
    localparam int IW = 4 + 2 * VAR_W + WIDTH;

    logic             clk = 0, rst = 1, start = 0;
    logic             busy, done, fetch_req, fetch_ack = 0;
    logic [2:0]       outcome;
    logic [CNT_W-1:0] steps;
    logic [PC_W-1:0]  fetch_addr;
    logic [IW-1:0]    fetch_data = '0;
    logic             choice = 0, var_we = 0;
    logic [VAR_W-1:0] var_addr = '0;
    logic [WIDTH-1:0] var_wdata = '0, var_rdata;

    logic [IW-1:0] prog [64];
    int ack_delay = 0, wcnt = 0;
    int n_run = 0, n_fail = 0;

    gcl_step_engine #(
        .WIDTH(WIDTH), .NVARS(NVARS), .PC_W(PC_W),
        .HDEPTH(HDEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .outcome(outcome), .steps(steps), .fetch_req(fetch_req),
        .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .fetch_data(fetch_data), .choice(choice), .var_we(var_we),
        .var_addr(var_addr), .var_wdata(var_wdata), .var_rdata(var_rdata)
    );

    always #5 clk = ~clk;

    // fetch model: ack after ack_delay idle negedges, one cycle wide
    initial forever begin
        @(negedge clk);
        fetch_ack = 0;
        if (!fetch_req) wcnt = 0;
        else if (wcnt >= ack_delay) begin
            fetch_ack  = 1;
            fetch_data = prog[fetch_addr[5:0]];
            wcnt = 0;
        end else wcnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input int op, input int a,
                                         input int b, input int imm);
        return {WIDTH'(imm), VAR_W'(b), VAR_W'(a), 4'(op)};
    endfunction

    task automatic clr_prog();
        for (int i = 0; i < 64; i++) prog[i] = mk(9, 0, 0, 0);
    endtask

    task automatic wr_var(input int a, input int d);
        @(negedge clk);
        var_we = 1; var_addr = VAR_W'(a); var_wdata = WIDTH'(d);
        @(negedge clk);
        var_we = 0;
    endtask

    task automatic chk_var(input string tag, input int a, input int exp);
        var_addr = VAR_W'(a);
        #1;
        check(tag, 32'(var_rdata), 32'(exp));
    endtask

    task automatic run(input string tag);
        bit seen = 0;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (done) seen = 1;
            else @(negedge clk);
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
    endtask

    initial begin
        clr_prog();
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_out", 32'(outcome), 0);
        check("rst_steps", 32'(steps), 0);
        check("rst_freq", 32'(fetch_req), 0);
        rst = 0;
        chk_var("rst_v0", 0, 0);

        // v1 = v0 + 3; HALT
        wr_var(0, 5);
        prog[0] = mk(1, 1, 0, 3);
        prog[1] = mk(9, 0, 0, 0);
        run("asg");
        check("asg_out", 32'(outcome), 0);
        check("asg_steps", 32'(steps), 2);
        chk_var("asg_v1", 1, 8);

        // start in DONE: done drops, busy rises
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        check("restart_done", 32'(done), 0);
        check("restart_busy", 32'(busy), 1);
        repeat (10) @(negedge clk);
        chk_var("restart_v1", 1, 8);

        // a==b reads old value, modulo wrap
        clr_prog();
        wr_var(4, 16'hFFFF);
        prog[0] = mk(1, 4, 4, 2);
        run("wrap");
        chk_var("wrap_v4", 4, 1);

        clr_prog();
        prog[0] = mk(2, 2, 0, 0);
        run("asrt");
        check("asrt_out", 32'(outcome), 2);
        check("asrt_steps", 32'(steps), 1);
        prog[0] = mk(3, 2, 0, 0);
        run("asum");
        check("asum_out", 32'(outcome), 3);
        check("asum_steps", 32'(steps), 1);
        prog[0] = mk(2, 1, 0, 0);
        run("asrt_ok");
        check("asrt_ok_out", 32'(outcome), 0);
        check("asrt_ok_steps", 32'(steps), 2);

        // TRY 4; RAISE; HALT; HALT; v0++; HALT
        clr_prog();
        wr_var(0, 0);
        prog[0] = mk(6, 0, 0, 4);
        prog[1] = mk(8, 0, 0, 0);
        prog[4] = mk(1, 0, 0, 1);
        run("catch");
        check("catch_out", 32'(outcome), 0);
        check("catch_steps", 32'(steps), 4);
        check("catch_sp", 32'(dut.sp), 0);
        chk_var("catch_v0", 0, 1);

        clr_prog();
        for (int i = 0; i <= HDEPTH; i++) prog[i] = mk(6, 0, 0, 10);
        run("ovf");
        check("ovf_out", 32'(outcome), 4);
        check("ovf_steps", 32'(steps), HDEPTH + 1);
        clr_prog();
        prog[0] = mk(7, 0, 0, 0);
        run("unf");
        check("unf_out", 32'(outcome), 5);
        check("unf_steps", 32'(steps), 1);
        prog[0] = mk(8, 0, 0, 0);
        run("exc");
        check("exc_out", 32'(outcome), 1);
        check("exc_steps", 32'(steps), 1);

        prog[0] = mk(5, 0, 0, 0);
        run("tmo");
        check("tmo_out", 32'(outcome), 6);
        check("tmo_steps", 32'(steps), 15);

        // CHOICE 2; v3++; HALT
        clr_prog();
        prog[0] = mk(4, 0, 0, 2);
        prog[1] = mk(1, 3, 3, 1);
        choice = 1;
        run("ch1");
        check("ch1_steps", 32'(steps), 2);
        chk_var("ch1_v3", 3, 0);
        choice = 0;
        ack_delay = 3;
        run("ch0");
        check("ch0_steps", 32'(steps), 3);
        check("ch0_out", 32'(outcome), 0);
        chk_var("ch0_v3", 3, 1);

        // reset mid-run
        clr_prog();
        prog[0] = mk(5, 0, 0, 0);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        check("mid_busy_pre", 32'(busy), 1);
        rst = 1;
        #1;
        check("mid_busy", 32'(busy), 0);
        check("mid_done", 32'(done), 0);
        check("mid_steps", 32'(steps), 0);
        check("mid_out", 32'(outcome), 0);
        check("mid_freq", 32'(fetch_req), 0);
        chk_var("mid_v3", 3, 0);
        @(negedge clk);
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
